// File: rtl/branch_predictor_pkg.sv
// Shared defaults and types for the BTB-based dynamic branch predictor.
package branch_predictor_pkg;

    localparam int unsigned BP_WORD_LEN = 32;
    localparam int unsigned BP_ENTRIES  = 16;
    localparam int unsigned BP_TAG_BITS = 8;
    localparam int unsigned BP_CTR_BITS = 2;
    localparam int unsigned BP_PERF_LEN = 32;

    // Entry layout at the default widths; the top rebuilds it from its own parameters.
    typedef struct packed {
        logic                   valid;
        logic [BP_TAG_BITS-1:0] tag;
        logic [BP_WORD_LEN-1:0] target;
    } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with synchronous active-low reset and parallel load.
module branch_predictor_sat_counter #(
    parameter int unsigned     WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_d, cnt_q;

    // Load wins over inc, inc over dec; both directions stop at the rails.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// BTB plus per-entry saturating direction counters; combinational IF lookup,
// EXE-side resolve that flags mispredicts and trains the tables on the next edge.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned WORD_LEN    = BP_WORD_LEN,
    parameter int unsigned BTB_ENTRIES = BP_ENTRIES,
    parameter int unsigned TAG_BITS    = BP_TAG_BITS,
    parameter int unsigned CTR_BITS    = BP_CTR_BITS,
    parameter int unsigned PERF_LEN    = BP_PERF_LEN
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                enable,
    input  logic [WORD_LEN-1:0] pc_if,
    output logic                pred_taken,
    output logic [WORD_LEN-1:0] pred_target,
    input  logic                upd_valid,
    input  logic [WORD_LEN-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [WORD_LEN-1:0] upd_target,
    input  logic                upd_pred_taken,
    input  logic [WORD_LEN-1:0] upd_pred_target,
    output logic                mispredict,
    output logic [WORD_LEN-1:0] redirect_pc,
    output logic [PERF_LEN-1:0] perf_branches,
    output logic [PERF_LEN-1:0] perf_mispredicts
);

    localparam int unsigned IDX_BITS = $clog2(BTB_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [WORD_LEN-1:0] target;
    } entry_t;

    entry_t              entries_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_val   [BTB_ENTRIES];

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit, upd_en;
    logic [WORD_LEN-1:0] actual_next;

    assign lk_idx = pc_if[IDX_BITS+1:2];
    assign lk_tag = pc_if[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign up_idx = upd_pc[IDX_BITS+1:2];
    assign up_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    assign lk_hit = entries_q[lk_idx].valid && (entries_q[lk_idx].tag == lk_tag);
    assign up_hit = entries_q[up_idx].valid && (entries_q[up_idx].tag == up_tag);
    assign upd_en = upd_valid && enable;

    // Gated by nReset so the fetch side sees the cleared state while reset is held.
    assign pred_taken  = nReset && enable && lk_hit && ctr_val[lk_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? entries_q[lk_idx].target : pc_if + WORD_LEN'(4);

    assign actual_next = upd_taken ? upd_target : upd_pc + WORD_LEN'(4);
    assign mispredict  = upd_valid &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_valid ? actual_next : '0;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                entries_q[i] <= '0;
            end
        end else if (upd_en && upd_taken) begin
            entries_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target};
        end
    end

    // A taken miss allocates (or replaces an alias) and restarts the counter at weakly taken.
    for (genvar i = 0; i < int'(BTB_ENTRIES); i++) begin : g_ctr
        logic sel;
        assign sel = upd_en && (up_idx == IDX_BITS'(i));

        branch_predictor_sat_counter #(
            .WIDTH     (CTR_BITS),
            .RESET_VAL (CTR_WEAK_NT)
        ) u_ctr (
            .clk_i      (clk),
            .rst_ni     (nReset),
            .inc_i      (sel && upd_taken && up_hit),
            .dec_i      (sel && !upd_taken && up_hit),
            .load_i     (sel && upd_taken && !up_hit),
            .load_val_i (CTR_WEAK_T),
            .cnt_o      (ctr_val[i])
        );
    end

    branch_predictor_sat_counter #(
        .WIDTH     (PERF_LEN),
        .RESET_VAL ('0)
    ) u_perf_branches (
        .clk_i      (clk),
        .rst_ni     (nReset),
        .inc_i      (upd_en),
        .dec_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (perf_branches)
    );

    branch_predictor_sat_counter #(
        .WIDTH     (PERF_LEN),
        .RESET_VAL ('0)
    ) u_perf_mispredicts (
        .clk_i      (clk),
        .rst_ni     (nReset),
        .inc_i      (mispredict && enable),
        .dec_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .cnt_o      (perf_mispredicts)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: scenario tasks with a queue of expected results.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        nReset, enable, upd_valid, upd_taken, upd_pred_taken;
    logic [31:0] pc_if, upd_pc, upd_target, upd_pred_target;
    logic        pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc, perf_branches, perf_mispredicts;
    logic        p4_pred_taken, p4_mispredict;
    logic [31:0] p4_pred_target, p4_redirect_pc;
    logic [3:0]  p4_branches, p4_mispredicts;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] want;
    logic [31:0] exp_br = 0, exp_mp = 0;
    logic [3:0]  exp_br4 = 0, exp_mp4 = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .nReset(nReset), .enable(enable), .pc_if(pc_if),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .perf_branches(perf_branches),
        .perf_mispredicts(perf_mispredicts)
    );

    branch_predictor #(.PERF_LEN(4)) dut4 (
        .clk(clk), .nReset(nReset), .enable(enable), .pc_if(pc_if),
        .pred_taken(p4_pred_taken), .pred_target(p4_pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(p4_mispredict),
        .redirect_pc(p4_redirect_pc), .perf_branches(p4_branches),
        .perf_mispredicts(p4_mispredicts)
    );

    task automatic drive_lookup(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                input string nm);
        @(negedge clk);
        upd_valid = 1'b0;
        pc_if     = pc;
        exp_q.push_back({31'b0, tk});
        exp_q.push_back(tgt);
        #1;
        want = exp_q.pop_front(); checks++;
        if (pred_taken !== want[0]) begin
            errors++; $display("FAIL %s pred_taken: got %0b want %0b", nm, pred_taken, want[0]);
        end
        want = exp_q.pop_front(); checks++;
        if (pred_target !== want) begin
            errors++; $display("FAIL %s pred_target: got %h want %h", nm, pred_target, want);
        end
        checks++;
        if (mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL %s idle_resolve: got %0b/%h want 0/00000000", nm, mispredict, redirect_pc);
        end
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                                input logic ptk, input logic [31:0] ptgt, input logic mis,
                                input string nm);
        @(negedge clk);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        pc_if           = pc;
        exp_q.push_back({31'b0, mis});
        exp_q.push_back(tk ? tgt : pc + 32'd4);
        #1;
        want = exp_q.pop_front(); checks++;
        if (mispredict !== want[0]) begin
            errors++; $display("FAIL %s mispredict: got %0b want %0b", nm, mispredict, want[0]);
        end
        want = exp_q.pop_front(); checks++;
        if (redirect_pc !== want) begin
            errors++; $display("FAIL %s redirect_pc: got %h want %h", nm, redirect_pc, want);
        end
        if (enable) begin
            exp_br++;
            if (exp_br4 != 4'hf) exp_br4++;
            if (mis) begin
                exp_mp++;
                if (exp_mp4 != 4'hf) exp_mp4++;
            end
        end
    endtask

    task automatic check_perf(input string nm);
        checks++;
        if (perf_branches !== exp_br) begin
            errors++; $display("FAIL %s perf_branches: got %0d want %0d", nm, perf_branches, exp_br);
        end
        checks++;
        if (perf_mispredicts !== exp_mp) begin
            errors++;
            $display("FAIL %s perf_mispredicts: got %0d want %0d", nm, perf_mispredicts, exp_mp);
        end
        checks++;
        if (p4_branches !== exp_br4 || p4_mispredicts !== exp_mp4) begin
            errors++;
            $display("FAIL %s perf4: got %0d/%0d want %0d/%0d", nm, p4_branches, p4_mispredicts,
                     exp_br4, exp_mp4);
        end
    endtask

    task automatic test_reset();
        // A taken update is held on the resolve port throughout reset; reset must win.
        nReset = 1'b0; enable = 1'b1; pc_if = 32'h100;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200;
        upd_pred_taken = 1'b0; upd_pred_target = 32'h104;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
            errors++;
            $display("FAIL in_reset_lookup: got %0b/%h want 0/00000104", pred_taken, pred_target);
        end
        @(negedge clk);
        nReset = 1'b1; upd_valid = 1'b0;
        drive_lookup(32'h100, 1'b0, 32'h104, "reset_lookup");
        check_perf("reset");
    endtask

    task automatic test_first_taken();
        drive_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, "first_taken");
        drive_lookup(32'h100, 1'b1, 32'h200, "first_lookup");
        check_perf("first_taken");
    endtask

    task automatic test_counter();
        drive_update(32'h100, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, "nt1");
        drive_lookup(32'h100, 1'b0, 32'h104, "nt1_lookup");
        drive_update(32'h100, 1'b0, 32'h200, 1'b0, 32'h104, 1'b0, "nt2");
        drive_lookup(32'h100, 1'b0, 32'h104, "nt2_lookup");
        drive_update(32'h100, 1'b0, 32'h200, 1'b0, 32'h104, 1'b0, "nt3_hold");
        drive_lookup(32'h100, 1'b0, 32'h104, "nt3_lookup");
        drive_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, "t_from0");
        drive_lookup(32'h100, 1'b0, 32'h104, "t_from0_lookup");
        drive_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, "t_from1");
        drive_lookup(32'h100, 1'b1, 32'h200, "t_from1_lookup");
        check_perf("counter");
    endtask

    task automatic test_alias();
        drive_update(32'h140, 1'b1, 32'h400, 1'b0, 32'h144, 1'b1, "alias_upd");
        drive_lookup(32'h100, 1'b0, 32'h104, "alias_old_miss");
        drive_lookup(32'h140, 1'b1, 32'h400, "alias_new_hit");
    endtask

    task automatic test_same_cycle();
        drive_update(32'h140, 1'b0, 32'h400, 1'b1, 32'h400, 1'b1, "same_upd");
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h400);
        want = exp_q.pop_front(); checks++;
        if (pred_taken !== want[0]) begin
            errors++; $display("FAIL same_old_taken: got %0b want %0b", pred_taken, want[0]);
        end
        want = exp_q.pop_front(); checks++;
        if (pred_target !== want) begin
            errors++; $display("FAIL same_old_target: got %h want %h", pred_target, want);
        end
        drive_lookup(32'h140, 1'b0, 32'h144, "same_after");
    endtask

    task automatic test_jalr();
        drive_update(32'h208, 1'b1, 32'h200, 1'b0, 32'h20c, 1'b1, "jalr_train");
        drive_lookup(32'h208, 1'b1, 32'h200, "jalr_lookup");
        drive_update(32'h208, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, "jalr_wrong_tgt");
        drive_update(32'h208, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, "jalr_right");
        drive_lookup(32'h208, 1'b1, 32'h200, "jalr_after");
        check_perf("jalr");
    endtask

    task automatic test_disable();
        @(negedge clk);
        enable = 1'b0;
        drive_lookup(32'h208, 1'b0, 32'h20c, "dis_lookup");
        drive_update(32'h300, 1'b1, 32'h500, 1'b0, 32'h304, 1'b1, "dis_taken");
        drive_update(32'h208, 1'b0, 32'h200, 1'b0, 32'h20c, 1'b0, "dis_nt_a");
        drive_update(32'h208, 1'b0, 32'h200, 1'b0, 32'h20c, 1'b0, "dis_nt_b");
        drive_lookup(32'h300, 1'b0, 32'h304, "dis_lookup2");
        check_perf("disabled");
        enable = 1'b1;
        drive_lookup(32'h300, 1'b0, 32'h304, "dis_no_alloc");
        drive_lookup(32'h208, 1'b1, 32'h200, "dis_ctr_kept");
        check_perf("reenabled");
    endtask

    task automatic test_back_to_back_saturate();
        for (int i = 0; i < 20; i++) begin
            drive_update(32'h400, 1'b1, 32'h800, 1'b0, 32'h404, 1'b1, "b2b");
        end
        drive_lookup(32'h400, 1'b1, 32'h800, "b2b_lookup");
        check_perf("saturate");
    endtask

    initial begin
        nReset = 1'b0; enable = 1'b1; pc_if = '0; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        test_reset();
        test_first_taken();
        test_counter();
        test_alias();
        test_same_cycle();
        test_jalr();
        test_disable();
        test_back_to_back_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
